// File: rtl/alu_regfile_unit.sv
// CPU datapath core: combinational ALU with flag generation, plus a register file
// with two asynchronous read ports, one synchronous write port and a hardwired-zero R0.
module alu_regfile_unit #(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 32,
    localparam int AW      = $clog2(NUM_REGS),
    localparam int SHW     = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     addr_a,
    output logic [DATA_W-1:0] data_a,
    input  logic [AW-1:0]     addr_b,
    output logic [DATA_W-1:0] data_b,
    input  logic [AW-1:0]     addr_w,
    input  logic [DATA_W-1:0] data_w,
    input  logic              write_en,
    input  logic [DATA_W-1:0] alu_a,
    input  logic [DATA_W-1:0] alu_b,
    input  logic [3:0]        alu_op,
    input  logic [7:0]        flags_in,
    output logic [DATA_W-1:0] alu_result,
    output logic [7:0]        flags_out
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (write_en && (addr_w != '0)) begin
            regs_q[addr_w] <= data_w;
        end
    end

    // No write bypass: a same-cycle read sees the value stored before the edge.
    assign data_a = (rst || addr_a == '0) ? '0 : regs_q[addr_a];
    assign data_b = (rst || addr_b == '0) ? '0 : regs_q[addr_b];

    function automatic logic add_ovf(input logic signed [DATA_W-1:0] a,
                                     input logic signed [DATA_W-1:0] b,
                                     input logic signed [DATA_W-1:0] r);
        return (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
    endfunction

    function automatic logic sub_ovf(input logic signed [DATA_W-1:0] a,
                                     input logic signed [DATA_W-1:0] b,
                                     input logic signed [DATA_W-1:0] r);
        return (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
    endfunction

    logic                     cin;
    logic [SHW-1:0]           sh;
    logic [DATA_W-1:0]        res;
    logic                     c_flag;
    logic                     v_flag;
    logic [DATA_W:0]          shl_w;
    logic [DATA_W:0]          shr_w;
    logic signed [DATA_W:0]   sar_w;
    logic [2*DATA_W-1:0]      rol_w;
    logic [2*DATA_W-1:0]      prod_w;
    logic                     unused_flags;

    assign cin          = flags_in[0];
    assign sh           = alu_b[SHW-1:0];
    assign unused_flags = ^flags_in[3:1];

    always_comb begin
        res    = '0;
        c_flag = 1'b0;
        v_flag = 1'b0;
        shl_w  = {1'b0, alu_a} << sh;
        shr_w  = {alu_a, 1'b0} >> sh;
        sar_w  = $signed({alu_a, 1'b0}) >>> sh;
        rol_w  = {alu_a, alu_a} << sh;
        prod_w = {{DATA_W{1'b0}}, alu_a} * {{DATA_W{1'b0}}, alu_b};
        case (alu_op)
            4'h0: begin
                {c_flag, res} = {1'b0, alu_a} + {1'b0, alu_b};
                v_flag = add_ovf(alu_a, alu_b, res);
            end
            4'h1, 4'hC: begin
                res    = alu_a - alu_b;
                c_flag = alu_a < alu_b;
                v_flag = sub_ovf(alu_a, alu_b, res);
            end
            4'h2: begin
                {c_flag, res} = {1'b0, alu_a} + {1'b0, alu_b} + {{DATA_W{1'b0}}, cin};
                v_flag = add_ovf(alu_a, alu_b, res);
            end
            4'h3: begin
                res    = alu_a - alu_b - {{(DATA_W-1){1'b0}}, cin};
                c_flag = {1'b0, alu_a} < ({1'b0, alu_b} + {{DATA_W{1'b0}}, cin});
                v_flag = sub_ovf(alu_a, alu_b, res);
            end
            4'h4: res = alu_a & alu_b;
            4'h5: res = alu_a | alu_b;
            4'h6: res = alu_a ^ alu_b;
            4'h7: res = ~alu_a;
            // Shifts keep the last bit shifted out in the extra bit of the widened operand.
            4'h8: {c_flag, res} = shl_w;
            4'h9: {res, c_flag} = shr_w;
            4'hA: {res, c_flag} = sar_w;
            4'hB: begin
                res    = rol_w[2*DATA_W-1:DATA_W];
                c_flag = res[0];
            end
            4'hD: begin
                res    = prod_w[DATA_W-1:0];
                c_flag = |prod_w[2*DATA_W-1:DATA_W];
            end
            4'hE: res = alu_b;
            default: res = alu_a;
        endcase
        if ((alu_op == 4'h8 || alu_op == 4'h9 || alu_op == 4'hA) && sh == '0) begin
            res    = alu_a;
            c_flag = cin;
        end
    end

    assign alu_result = res;
    assign flags_out  = {flags_in[7:4], v_flag, res[DATA_W-1], (res == '0), c_flag};

endmodule

// File: tb/tb_alu_regfile_unit.sv
// Directed bench for alu_regfile_unit: register-file sequences plus a table of ALU vectors.
module tb_alu_regfile_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  addr_a, addr_b, addr_w;
    logic [31:0] data_a, data_b, data_w;
    logic        write_en;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_op;
    logic [7:0]  flags_in, flags_out;

    int n_cmp = 0;
    int n_err = 0;

    alu_regfile_unit dut (
        .clk(clk), .rst(rst),
        .addr_a(addr_a), .data_a(data_a),
        .addr_b(addr_b), .data_b(data_b),
        .addr_w(addr_w), .data_w(data_w), .write_en(write_en),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .flags_in(flags_in), .alu_result(alu_result), .flags_out(flags_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  fin;
        logic [31:0] exp_res;
        logic [7:0]  exp_flags;
        string       name;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin
        // flags = {fin[7:4], V, N, Z, C}
        vecs[0]  = '{4'h0, 32'h7FFFFFFF, 32'h00000001, 8'h00, 32'h80000000, 8'h0C, "add_ovf"};
        vecs[1]  = '{4'h0, 32'hFFFFFFFF, 32'h00000001, 8'h00, 32'h00000000, 8'h03, "add_carry"};
        vecs[2]  = '{4'h1, 32'h00000005, 32'h00000007, 8'h00, 32'hFFFFFFFE, 8'h05, "sub_borrow"};
        vecs[3]  = '{4'hC, 32'h0000000A, 32'h0000000A, 8'h00, 32'h00000000, 8'h02, "cmp_eq"};
        vecs[4]  = '{4'h2, 32'h00000001, 32'h00000001, 8'h01, 32'h00000003, 8'h00, "adc"};
        vecs[5]  = '{4'h4, 32'hF0F0F0F0, 32'hFF00FF00, 8'hA0, 32'hF000F000, 8'hA4, "and_fin"};
        vecs[6]  = '{4'h5, 32'hF0F0F0F0, 32'hFF00FF00, 8'h00, 32'hFFF0FFF0, 8'h04, "or"};
        vecs[7]  = '{4'h6, 32'hF0F0F0F0, 32'hFF00FF00, 8'h00, 32'h0FF00FF0, 8'h00, "xor"};
        vecs[8]  = '{4'h8, 32'h80000001, 32'h00000001, 8'h00, 32'h00000002, 8'h01, "shl"};
        vecs[9]  = '{4'hA, 32'h80000000, 32'h00000004, 8'h00, 32'hF8000000, 8'h04, "sar"};
        vecs[10] = '{4'h9, 32'h12345678, 32'h00000000, 8'h01, 32'h12345678, 8'h01, "shr0"};
        vecs[11] = '{4'hD, 32'h00010000, 32'h00010000, 8'h00, 32'h00000000, 8'h03, "mul_hi"};
        vecs[12] = '{4'h7, 32'h00000000, 32'h00000000, 8'h00, 32'hFFFFFFFF, 8'h04, "not"};
        vecs[13] = '{4'h3, 32'h00000005, 32'h00000005, 8'h01, 32'hFFFFFFFF, 8'h05, "sbb"};
        vecs[14] = '{4'hB, 32'h80000001, 32'h00000004, 8'h00, 32'h00000018, 8'h00, "rol"};
        vecs[15] = '{4'hE, 32'h00000001, 32'h00000000, 8'h00, 32'h00000000, 8'h02, "passb"};
        vecs[16] = '{4'hF, 32'h80000000, 32'h00000005, 8'hF1, 32'h80000000, 8'hF4, "passa"};
        vecs[17] = '{4'h9, 32'h80000000, 32'h0000001F, 8'h00, 32'h00000001, 8'h00, "shr31"};
        vecs[18] = '{4'h1, 32'h80000000, 32'h00000001, 8'h00, 32'h7FFFFFFF, 8'h08, "sub_ovf"};

        rst = 1'b1; write_en = 1'b0; addr_a = '0; addr_b = '0; addr_w = '0; data_w = '0;
        alu_a = '0; alu_b = '0; alu_op = '0; flags_in = '0;
        #3;
        for (int i = 0; i < 16; i++) begin
            addr_a = 4'(i);
            addr_b = 4'(15 - i);
            #1;
            check($sformatf("rst_a%0d", i), data_a, 32'h0);
            check($sformatf("rst_b%0d", 15 - i), data_b, 32'h0);
        end
        @(negedge clk); rst = 1'b0;

        // Write R5; same-cycle read still shows the old value.
        @(negedge clk);
        addr_w = 4'd5; data_w = 32'hDEADBEEF; write_en = 1'b1; addr_a = 4'd5; addr_b = 4'd5;
        #1 check("r5_before_edge", data_a, 32'h0);
        @(posedge clk); #1;
        write_en = 1'b0;
        check("r5_a_after", data_a, 32'hDEADBEEF);
        check("r5_b_after", data_b, 32'hDEADBEEF);

        @(negedge clk);
        addr_w = 4'd3; data_w = 32'h00000033; write_en = 1'b1;
        @(posedge clk); #1;
        write_en = 1'b0; addr_a = 4'd3;
        #1 check("r3_written", data_a, 32'h00000033);

        @(negedge clk);
        addr_w = 4'd3; data_w = 32'h00000099; write_en = 1'b0;
        @(posedge clk); #1;
        check("r3_we0", data_a, 32'h00000033);

        @(negedge clk);
        addr_w = 4'd0; data_w = 32'h00001234; write_en = 1'b1; addr_b = 4'd0;
        @(posedge clk); #1;
        write_en = 1'b0;
        check("r0_zero", data_b, 32'h0);
        addr_b = 4'd5;
        #1 check("r5_kept", data_b, 32'hDEADBEEF);

        // Asynchronous reset between clock edges.
        @(negedge clk);
        addr_a = 4'd5; addr_b = 4'd3;
        #2 rst = 1'b1;
        #1;
        check("async_rst_a", data_a, 32'h0);
        check("async_rst_b", data_b, 32'h0);
        @(negedge clk); rst = 1'b0;
        #1;
        check("post_rst_a", data_a, 32'h0);
        check("post_rst_b", data_b, 32'h0);

        for (int i = 0; i < 19; i++) begin
            alu_op = vecs[i].op; alu_a = vecs[i].a; alu_b = vecs[i].b; flags_in = vecs[i].fin;
            #1;
            check({vecs[i].name, "_res"}, alu_result, vecs[i].exp_res);
            check({vecs[i].name, "_flg"}, {24'h0, flags_out}, {24'h0, vecs[i].exp_flags});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_regfile_unit.md
Name: alu_regfile_unit

Overview:
- Datapath core for the 32-bit CPU: a combinational 32-bit ALU with 8-bit flag in/out, and a 16 x 32-bit register file with two asynchronous read ports and one synchronous write port.
- The CPU control FSM drives all ports.
- The ALU and register-file port groups are independent; the CPU connects read data to the ALU externally.

Parameters:
- NUM_REGS, 16, number of registers; address width is 4 bits.
- DATA_W, 32, register and ALU datapath width.

Ports:
- clk  input  1  clock; register writes occur on the rising edge.
- rst  input  1  reset; asynchronous, active-high; clears all registers.
- addr_a  input  4  read port A address.
- data_a  output  32  read port A data, combinational.
- addr_b  input  4  read port B address.
- data_b  output  32  read port B data, combinational.
- addr_w  input  4  write address.
- data_w  input  32  write data.
- write_en  input  1  write enable.
- alu_a  input  32  ALU operand A.
- alu_b  input  32  ALU operand B.
- alu_op  input  4  ALU operation select.
- flags_in  input  8  incoming flags; bit0 carry is used by ADC/SBB/shift-by-0.
- alu_result  output  32  ALU result, combinational.
- flags_out  output  8  bit0 C, bit1 Z, bit2 N, bit3 V; bits 7:4 = flags_in[7:4].

Behaviour:

Register file
- rst high: all 16 registers clear to 0 immediately, independent of clk. data_a/data_b read 0 while rst is asserted.
- Write: on posedge clk with write_en=1 and rst=0, reg[addr_w] <= data_w.
- R0 is hardwired to zero. Writes to address 0 are ignored and R0 always reads 0.
- Reads are combinational. There is no write-to-read bypass: a write becomes visible on data_a/data_b after the clock edge.
- Both read ports may address the same register simultaneously.

ALU (purely combinational, zero latency, no dependence on clk/rst)
- 0 ADD: a+b; C = carry out; V = signed overflow.
- 1 SUB: a-b; C = borrow (1 when a<b unsigned); V = signed overflow.
- 2 ADC: a+b+flags_in[0].
- 3 SBB: a-b-flags_in[0]; C = borrow.
- 4 AND, 5 OR, 6 XOR: bitwise operations; C=0, V=0.
- 7 NOT: ~a; C=0, V=0.
- 8 SHL: a << b[4:0].
- 9 SHR: logical right shift by b[4:0].
- A SAR: arithmetic right shift by b[4:0].
- Shift flags: C = last bit shifted out; shift amount 0 gives result = a and C = flags_in[0]; V = 0.
- B ROL: rotate a left by b[4:0]; C = result[0]; V = 0.
- C CMP: result = a-b; flags identical to SUB. The caller decides whether to write the result back.
- D MUL: low 32 bits of unsigned a*b; C=1 if the upper 32 bits are non-zero; V=0.
- E PASSB: result = b; C=0, V=0.
- F PASSA: result = a; C=0, V=0.
- All ops: Z = (result==0); N = result[31].
- Arithmetic wraps modulo 2^32.

Test Plan:
- Reset, then read all addresses on both ports -> 0. Write R5=0xDEADBEEF with write_en=1 -> data_a(addr 5) reads 0xDEADBEEF only after the edge. Assert rst mid-run -> reads return 0 immediately.
- write_en=1, addr_w=0, data_w=0x1234 -> R0 still reads 0. write_en=0 with addr_w=3 -> R3 unchanged. Same-cycle read of a register being written returns the old value.
- ADD 0x7FFFFFFF+1 -> 0x80000000, flags N=1, V=1, C=0, Z=0. ADD 0xFFFFFFFF+1 -> 0, C=1, Z=1.
- SUB 5-7 -> 0xFFFFFFFE, C=1, N=1. CMP 10 vs 10 -> Z=1, C=0. ADC 1+1 with flags_in[0]=1 -> 3.
- AND/OR/XOR of 0xF0F0F0F0 and 0xFF00FF00 -> 0xF000F000 / 0xFFF0FFF0 / 0x0FF00FF0. flags_in=0xA0 -> flags_out[7:4]=0xA.
- SHL 0x80000001 by 1 -> 0x00000002, C=1. SAR 0x80000000 by 4 -> 0xF8000000. SHR by 0 -> result = a, C = flags_in[0]. MUL 0x10000 * 0x10000 -> 0, C=1, Z=1.
